// File: rtl/yasac_control_unit_pkg.sv
// rtl/yasac_control_unit_pkg.sv - YASAC controller opcodes, select codes, states and strobe bundle
package yasac_control_unit_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_IN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LOADIR = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEMWB  = 3'd5
  } state_t;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic       addr_sel;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       port_we;
  } strobes_t;

endpackage

// File: rtl/yasac_ctrl_decode.sv
// rtl/yasac_ctrl_decode.sv - state/opcode/zero to strobe vector and next-state table
module yasac_ctrl_decode
  import yasac_control_unit_pkg::*;
#(
  parameter int OPW = 4
) (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           start,
  output strobes_t       strobes,
  output state_t         next_state,
  output logic           illegal_op,
  output logic           retire
);

  // Strobes depend only on the current state and the (registered) IR opcode/zero flag
  always_comb begin
    strobes        = '0;
    strobes.wb_sel = WB_ALU;
    strobes.alu_op = ALU_PASS;
    next_state     = state;
    illegal_op     = 1'b0;
    retire         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_START;
      end
      ST_START: begin
        strobes.pc_clr = 1'b1;
        next_state     = ST_FETCH;
      end
      ST_FETCH: begin
        strobes.addr_sel = 1'b0;
        next_state       = ST_LOADIR;
      end
      ST_LOADIR: begin
        strobes.ir_load = 1'b1;
        strobes.pc_inc  = 1'b1;
        next_state      = ST_EXEC;
      end
      ST_EXEC: begin
        next_state = ST_FETCH;
        retire     = 1'b1;
        case (opcode)
          OPW'(OP_NOP): ;
          OPW'(OP_LDI): begin
            strobes.reg_we = 1'b1;
            strobes.wb_sel = WB_IMM;
          end
          OPW'(OP_LD): begin
            // Load retires in MEMWB, after the read data is available
            strobes.addr_sel = 1'b1;
            next_state       = ST_MEMWB;
            retire           = 1'b0;
          end
          OPW'(OP_ST): begin
            strobes.addr_sel = 1'b1;
            strobes.mem_we   = 1'b1;
          end
          OPW'(OP_ADD): begin
            strobes.reg_we = 1'b1;
            strobes.alu_op = ALU_ADD;
          end
          OPW'(OP_SUB): begin
            strobes.reg_we = 1'b1;
            strobes.alu_op = ALU_SUB;
          end
          OPW'(OP_AND): begin
            strobes.reg_we = 1'b1;
            strobes.alu_op = ALU_AND;
          end
          OPW'(OP_IN): begin
            strobes.reg_we = 1'b1;
            strobes.wb_sel = WB_IN;
          end
          OPW'(OP_OUT): strobes.port_we = 1'b1;
          OPW'(OP_JMP): strobes.pc_load = 1'b1;
          OPW'(OP_JZ):  strobes.pc_load = zero;
          OPW'(OP_HALT): next_state = ST_IDLE;
          default: illegal_op = 1'b1;
        endcase
      end
      ST_MEMWB: begin
        strobes.addr_sel = 1'b1;
        strobes.reg_we   = 1'b1;
        strobes.wb_sel   = WB_MEM;
        next_state       = ST_FETCH;
        retire           = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/yasac_control_unit.sv
// rtl/yasac_control_unit.sv - YASAC multicycle fetch/decode/execute controller
module yasac_control_unit
  import yasac_control_unit_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            ready,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  output logic            pc_clr,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            ir_load,
  output logic            addr_sel,
  output logic            mem_we,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic [2:0]      alu_op,
  output logic            port_we,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count
);

  state_t   state;
  state_t   next_state;
  strobes_t strobes;
  logic     illegal_op;
  logic     retire;

  yasac_ctrl_decode #(
    .OPW(OPW)
  ) u_decode (
    .state      (state),
    .opcode     (opcode),
    .zero       (zero),
    .start      (start),
    .strobes    (strobes),
    .next_state (next_state),
    .illegal_op (illegal_op),
    .retire     (retire)
  );

  // State register; reset returns to IDLE from anywhere and beats start
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Sticky illegal-opcode flag, cleared when a new program starts
  always_ff @(posedge clk) begin
    if (reset)                  illegal <= 1'b0;
    else if (state == ST_START) illegal <= 1'b0;
    else if (illegal_op)        illegal <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (reset)                  instr_count <= '0;
    else if (state == ST_START) instr_count <= '0;
    else if (retire)            instr_count <= instr_count + CNTW'(1);
  end

  assign ready    = (state == ST_IDLE);
  assign pc_clr   = strobes.pc_clr;
  assign pc_inc   = strobes.pc_inc;
  assign pc_load  = strobes.pc_load;
  assign ir_load  = strobes.ir_load;
  assign addr_sel = strobes.addr_sel;
  assign mem_we   = strobes.mem_we;
  assign reg_we   = strobes.reg_we;
  assign wb_sel   = strobes.wb_sel;
  assign alu_op   = strobes.alu_op;
  assign port_we  = strobes.port_we;

endmodule

// File: tb/tb_yasac_control_unit.sv
// tb/tb_yasac_control_unit.sv - randomized program traces against an instruction-level model
module tb_yasac_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, zero;
  logic [3:0] opcode;
  logic       ready, pc_clr, pc_inc, pc_load, ir_load, addr_sel, mem_we, reg_we, port_we, illegal;
  logic [1:0] wb_sel;
  logic [2:0] alu_op;
  logic [3:0] instr_count;

  yasac_control_unit #(.OPW(4), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .opcode(opcode), .zero(zero),
    .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
    .addr_sel(addr_sel), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_op(alu_op), .port_we(port_we), .illegal(illegal), .instr_count(instr_count)
  );

  logic [13:0] obs;
  assign obs = {ready, pc_clr, pc_inc, pc_load, ir_load, addr_sel, mem_we, reg_we,
                wb_sel, alu_op, port_we};

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      if (n_mismatched <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         st;
    logic [3:0] op;
    bit         z;
    logic [13:0] exp;
    logic [3:0] cnt;
    bit         ill;
  } cyc_t;

  cyc_t       q[$];
  logic [3:0] prog_q[$];
  bit         zq[$];
  int         m_cnt, reset_at, cyc_idx;
  bit         m_ill, aborted;

  // {ready, pc_clr, pc_inc, pc_load, ir_load, addr_sel, mem_we, reg_we, wb_sel, alu_op, port_we}
  function automatic logic [13:0] vec(bit rdy, bit clr, bit inc, bit pld, bit ir, bit as,
                                      bit we, bit rw, int wb, int alu, bit pw);
    logic [1:0] w;
    logic [2:0] a;
    w = wb[1:0];
    a = alu[2:0];
    return {rdy, clr, inc, pld, ir, as, we, rw, w, a, pw};
  endfunction

  function automatic logic [13:0] exec_exp(logic [3:0] op, bit z);
    case (op)
      4'h1: return vec(0,0,0,0,0,0,0,1,2,0,0);
      4'h2: return vec(0,0,0,0,0,1,0,0,0,0,0);
      4'h3: return vec(0,0,0,0,0,1,1,0,0,0,0);
      4'h4: return vec(0,0,0,0,0,0,0,1,0,1,0);
      4'h5: return vec(0,0,0,0,0,0,0,1,0,2,0);
      4'h6: return vec(0,0,0,0,0,0,0,1,0,3,0);
      4'h7: return vec(0,0,0,0,0,0,0,1,3,0,0);
      4'h8: return vec(0,0,0,0,0,0,0,0,0,0,1);
      4'h9: return vec(0,0,0,1,0,0,0,0,0,0,0);
      4'hA: return vec(0,0,0,z,0,0,0,0,0,0,0);
      default: return vec(0,0,0,0,0,0,0,0,0,0,0);
    endcase
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic emit(input bit st, input logic [3:0] op, input bit z, input logic [13:0] e);
    cyc_t r;
    r.rst = (cyc_idx == reset_at);
    r.st  = st;
    r.op  = op;
    r.z   = z;
    r.exp = e;
    r.cnt = 4'(m_cnt);
    r.ill = m_ill;
    q.push_back(r);
    cyc_idx++;
    if (r.rst) begin
      aborted = 1'b1;
      m_cnt   = 0;
      m_ill   = 1'b0;
    end
  endtask

  task automatic gen_idle(input int n);
    reset_at = -1;
    for (int i = 0; i < n; i++) emit(1'b0, rnd_op(), rnd_bit(), vec(1,0,0,0,0,0,0,0,0,0,0));
  endtask

  // Expand the program in prog_q/zq into the cycle trace an ideal controller produces
  task automatic gen_run(input int rst_at);
    reset_at = rst_at;
    cyc_idx  = 0;
    aborted  = 1'b0;
    emit(1'b1, rnd_op(), rnd_bit(), vec(1,0,0,0,0,0,0,0,0,0,0));
    if (aborted) return;
    emit(rnd_bit(), rnd_op(), rnd_bit(), vec(0,1,0,0,0,0,0,0,0,0,0));
    if (aborted) return;
    m_cnt = 0;
    m_ill = 1'b0;
    foreach (prog_q[i]) begin
      emit(rnd_bit(), rnd_op(), rnd_bit(), vec(0,0,0,0,0,0,0,0,0,0,0));
      if (aborted) return;
      emit(rnd_bit(), rnd_op(), rnd_bit(), vec(0,0,1,0,1,0,0,0,0,0,0));
      if (aborted) return;
      emit(rnd_bit(), prog_q[i], zq[i], exec_exp(prog_q[i], zq[i]));
      if (aborted) return;
      if (prog_q[i] == 4'h2) begin
        emit(rnd_bit(), rnd_op(), rnd_bit(), vec(0,0,0,0,0,1,0,1,1,0,0));
        if (aborted) return;
      end
      m_cnt = (m_cnt + 1) % 16;
      if (prog_q[i] inside {[4'hB:4'hE]}) m_ill = 1'b1;
      if (prog_q[i] == 4'hF) return;
    end
  endtask

  task automatic set_prog(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input int n);
    logic [3:0] ops[4];
    ops = '{a, b, c, d};
    prog_q.delete();
    zq.delete();
    for (int i = 0; i < n; i++) begin
      prog_q.push_back(ops[i]);
      zq.push_back(rnd_bit());
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 4'h0;
    zero   = 1'b0;
    m_cnt  = 0;
    m_ill  = 1'b0;

    gen_idle(2);
    set_prog(4'h1, 4'h4, 4'h8, 4'hF, 4);
    gen_run(-1);
    gen_idle(2);
    set_prog(4'h2, 4'h3, 4'hF, 4'h0, 3);
    gen_run(-1);
    gen_idle(1);
    set_prog(4'hA, 4'hA, 4'h9, 4'hF, 4);
    zq[0] = 1'b0;
    zq[1] = 1'b1;
    gen_run(-1);
    gen_idle(1);
    set_prog(4'hC, 4'h1, 4'hF, 4'h0, 3);
    gen_run(-1);
    gen_idle(2);
    set_prog(4'hF, 4'h0, 4'h0, 4'h0, 1);
    gen_run(-1);
    gen_idle(1);
    set_prog(4'hD, 4'hF, 4'h0, 4'h0, 2);
    gen_run(-1);
    gen_idle(1);
    set_prog(4'h2, 4'hF, 4'h0, 4'h0, 2);
    gen_run(5);
    gen_idle(2);
    set_prog(4'h1, 4'hF, 4'h0, 4'h0, 2);
    gen_run(0);
    gen_idle(2);

    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(1, 24);
      prog_q.delete();
      zq.delete();
      for (int i = 0; i < len - 1; i++) begin
        prog_q.push_back(4'($urandom_range(0, 14)));
        zq.push_back(rnd_bit());
      end
      prog_q.push_back(4'hF);
      zq.push_back(rnd_bit());
      if ($urandom_range(0, 3) == 0) gen_run($urandom_range(0, 3 * len + 2));
      else                           gen_run(-1);
      gen_idle($urandom_range(1, 3));
    end

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_strobes", 16'(obs), 16'(vec(1,0,0,0,0,0,0,0,0,0,0)));
    check_eq("reset_count", 16'(instr_count), 16'h0);
    check_eq("reset_illegal", 16'(illegal), 16'h0);

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      reset  = q[i].rst;
      start  = q[i].st;
      opcode = q[i].op;
      zero   = q[i].z;
      @(negedge clk);
      check_eq($sformatf("trace@%0d", i), 16'(obs), 16'(q[i].exp));
      check_eq($sformatf("count@%0d", i), 16'(instr_count), 16'(q[i].cnt));
      check_eq($sformatf("illegal@%0d", i), 16'(illegal), 16'(q[i].ill));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
